// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse symbol sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MARK       = 3'd1,
    ST_SPACE      = 3'd2,
    ST_LETTER_GAP = 3'd3,
    ST_WORD_GAP   = 3'd4
  } state_t;

  localparam int DEF_DOT_UNITS        = 1;
  localparam int DEF_DASH_UNITS       = 3;
  localparam int DEF_LETTER_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS   = 7;
  localparam int SPACE_UNITS          = 1;

  localparam int         UNIT_W      = 8;
  localparam logic [2:0] SYM_LEN_MAX = 3'd5;

  // Lengths 6 and 7 cannot be represented by a 5-bit code, so they saturate.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > SYM_LEN_MAX) ? SYM_LEN_MAX : len;
  endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Morse unit prescaler: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
module unit_tick_gen #(
  parameter int CLK_DIV = 100000000,
  parameter int CNT_W   = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = (count_reg == TERMINAL) ? '0 : count_reg + 1'b1;
    end
  end

  // tick is registered so it is high exactly while count_reg sits at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      tick      <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick      <= (count_next == TERMINAL);
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse keying sequencer: marks, element spaces, letter and word gaps in unit time.
// Optional square-wave tone output enabled by defining MORSE_TONE_EN.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int CLK_DIV          = 100000000,
  parameter int CNT_W            = 28,
  parameter int DOT_UNITS        = DEF_DOT_UNITS,
  parameter int DASH_UNITS       = DEF_DASH_UNITS,
  parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
`ifdef MORSE_TONE_EN
  ,
  parameter int TONE_DIV         = 50000
`endif
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SYM_VALID,
  output logic       SYM_READY,
  input  logic [2:0] SYM_LEN,
  input  logic [4:0] SYM_CODE,
  output logic       MORSE_OUT,
  output logic       BUSY,
  output logic       UNIT_TICK
`ifdef MORSE_TONE_EN
  ,
  output logic       TONE_OUT
`endif
);

  localparam logic [UNIT_W-1:0] DOT_U    = UNIT_W'(DOT_UNITS);
  localparam logic [UNIT_W-1:0] DASH_U   = UNIT_W'(DASH_UNITS);
  localparam logic [UNIT_W-1:0] SPACE_U  = UNIT_W'(SPACE_UNITS);
  localparam logic [UNIT_W-1:0] LETTER_U = UNIT_W'(LETTER_GAP_UNITS);
  localparam logic [UNIT_W-1:0] WORD_U   = UNIT_W'(WORD_GAP_UNITS);

  state_t            state_reg, state_next;
  logic [UNIT_W-1:0] units_reg, units_next;
  logic [2:0]        elems_reg, elems_next;
  logic [4:0]        shift_reg, shift_next;
  logic [2:0]        len_clamped;
  logic              xfer;

  assign xfer        = SYM_VALID && SYM_READY;
  assign len_clamped = clamp_len(SYM_LEN);

  unit_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_unit_tick_gen (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clear  (xfer),
    .enable (BUSY),
    .tick   (UNIT_TICK)
  );

  always_comb begin
    state_next = state_reg;
    units_next = units_reg;
    elems_next = elems_reg;
    shift_next = shift_reg;
    if (state_reg == ST_IDLE) begin
      if (xfer) begin
        shift_next = SYM_CODE;
        elems_next = len_clamped;
        if (len_clamped == 3'd0) begin
          state_next = ST_WORD_GAP;
          units_next = WORD_U;
        end else begin
          state_next = ST_MARK;
          units_next = SYM_CODE[0] ? DASH_U : DOT_U;
        end
      end
    end else if (UNIT_TICK) begin
      if (units_reg > UNIT_W'(1)) begin
        units_next = units_reg - 1'b1;
      end else begin
        // Current state's time is used up on this tick.
        case (state_reg)
          ST_MARK: begin
            if (elems_reg > 3'd1) begin
              shift_next = shift_reg >> 1;
              elems_next = elems_reg - 1'b1;
              state_next = ST_SPACE;
              units_next = SPACE_U;
            end else begin
              state_next = ST_LETTER_GAP;
              units_next = LETTER_U;
            end
          end
          ST_SPACE: begin
            state_next = ST_MARK;
            units_next = shift_reg[0] ? DASH_U : DOT_U;
          end
          default: begin
            state_next = ST_IDLE;
            units_next = '0;
            elems_next = '0;
          end
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      units_reg <= '0;
      elems_reg <= '0;
      shift_reg <= '0;
      MORSE_OUT <= 1'b0;
      BUSY      <= 1'b0;
      SYM_READY <= 1'b0;
    end else begin
      state_reg <= state_next;
      units_reg <= units_next;
      elems_reg <= elems_next;
      shift_reg <= shift_next;
      MORSE_OUT <= (state_next == ST_MARK);
      BUSY      <= (state_next != ST_IDLE);
      SYM_READY <= (state_next == ST_IDLE);
    end
  end

`ifdef MORSE_TONE_EN
  localparam int TONE_W = $clog2(TONE_DIV + 1);
  localparam logic [TONE_W-1:0] TONE_TERM = TONE_W'(TONE_DIV - 1);

  logic [TONE_W-1:0] tone_cnt_reg;

  // Divider restarts on every entry into MARK so each mark begins with the same phase.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tone_cnt_reg <= '0;
      TONE_OUT     <= 1'b0;
    end else if (state_next != ST_MARK || state_reg != ST_MARK) begin
      tone_cnt_reg <= '0;
      TONE_OUT     <= 1'b0;
    end else if (tone_cnt_reg == TONE_TERM) begin
      tone_cnt_reg <= '0;
      TONE_OUT     <= ~TONE_OUT;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Scoreboard bench for morse_symbol_sequencer with CLK_DIV=4; MORSE_OUT run lengths are queued and compared.
module tb_morse_symbol_sequencer;

  localparam int CLK_DIV = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SYM_VALID = 1'b0;
  logic [2:0] SYM_LEN = 3'd0;
  logic [4:0] SYM_CODE = 5'd0;
  logic       SYM_READY;
  logic       MORSE_OUT;
  logic       BUSY;
  logic       UNIT_TICK;
`ifdef MORSE_TONE_EN
  logic       TONE_OUT;
`endif

  int passed = 0;
  int total = 0;
  int exp_q[$];
  int obs_q[$];
  int ticks, busy_cycles, ready_at, transfers, overlap;

  always #5 CLK = ~CLK;

  morse_symbol_sequencer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (3)
`ifdef MORSE_TONE_EN
    ,
    .TONE_DIV (2)
`endif
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SYM_VALID (SYM_VALID),
    .SYM_READY (SYM_READY),
    .SYM_LEN   (SYM_LEN),
    .SYM_CODE  (SYM_CODE),
    .MORSE_OUT (MORSE_OUT),
    .BUSY      (BUSY),
    .UNIT_TICK (UNIT_TICK)
`ifdef MORSE_TONE_EN
    ,
    .TONE_OUT  (TONE_OUT)
`endif
  );

  // Handshake one symbol; returns at the negedge right after the transfer edge.
  task automatic send_sym(input logic [2:0] len, input logic [4:0] code);
    int waited;
    waited = 0;
    @(negedge CLK);
    while (SYM_READY !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    total++;
    if (SYM_READY !== 1'b1) $display("FAIL send_ready: SYM_READY=%b required 1", SYM_READY);
    else passed++;
    SYM_VALID = 1'b1;
    SYM_LEN   = len;
    SYM_CODE  = code;
    @(posedge CLK);
    @(negedge CLK);
    SYM_VALID = 1'b0;
    SYM_LEN   = 3'($urandom);
    SYM_CODE  = 5'($urandom);
    $display("sent len=%0d code=%05b", len, code);
  endtask

  // Sample ncycles negedges, recording MORSE_OUT runs as level*1000+length.
  task automatic observe(input int ncycles);
    logic cur;
    int   run;
    cur = MORSE_OUT;
    run = 0;
    ticks = 0; busy_cycles = 0; ready_at = -1; transfers = 0; overlap = 0;
    for (int i = 0; i < ncycles; i++) begin
      if (MORSE_OUT !== cur) begin
        obs_q.push_back(int'(cur) * 1000 + run);
        cur = MORSE_OUT;
        run = 0;
      end
      run++;
      if (UNIT_TICK === 1'b1) ticks++;
      if (BUSY === 1'b1) busy_cycles++;
      if (SYM_READY === 1'b1 && ready_at < 0) ready_at = i;
      if (SYM_READY === 1'b1 && SYM_VALID === 1'b1) transfers++;
      if (SYM_READY === 1'b1 && BUSY === 1'b1) overlap++;
      @(negedge CLK);
    end
    obs_q.push_back(int'(cur) * 1000 + run);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({MORSE_OUT, BUSY, UNIT_TICK, SYM_READY} !== 4'b0000)
      $display("FAIL reset_outputs: out/busy/tick/ready=%b required 0000", {MORSE_OUT, BUSY, UNIT_TICK, SYM_READY});
    else passed++;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (SYM_READY !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", SYM_READY, BUSY);
    else passed++;
    $display("reset done");
  endtask

  task automatic test_letter_a();
    int e, o;
    exp_q.push_back(1004); exp_q.push_back(4); exp_q.push_back(1012); exp_q.push_back(20);
    send_sym(3'd2, 5'b00010);
    observe(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL a_run: got %0d required %0d (level*1000+cycles)", o, e);
      else passed++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL a_extra_runs: got %0d extra required 0", obs_q.size());
    else passed++;
    obs_q.delete();
    total++;
    if (ready_at !== 32) $display("FAIL a_ready: got %0d required 32", ready_at); else passed++;
    total++;
    if (ticks !== 8) $display("FAIL a_ticks: got %0d required 8", ticks); else passed++;
    total++;
    if (busy_cycles !== 32) $display("FAIL a_busy: got %0d required 32", busy_cycles); else passed++;
  endtask

  task automatic test_word_space();
    int e, o;
    exp_q.push_back(36);
    send_sym(3'd0, 5'b10101);
    observe(36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL space_run: got %0d required %0d", o, e);
      else passed++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL space_extra_runs: got %0d required 0", obs_q.size()); else passed++;
    obs_q.delete();
    total++;
    if (busy_cycles !== 28) $display("FAIL space_busy: got %0d required 28", busy_cycles); else passed++;
    total++;
    if (ready_at !== 28) $display("FAIL space_ready: got %0d required 28", ready_at); else passed++;
    total++;
    if (ticks !== 7) $display("FAIL space_ticks: got %0d required 7", ticks); else passed++;
  endtask

  task automatic test_back_to_back();
    int e, o, waited;
    exp_q.push_back(1004); exp_q.push_back(13); exp_q.push_back(1012); exp_q.push_back(11);
    waited = 0;
    @(negedge CLK);
    while (SYM_READY !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    total++;
    if (SYM_READY !== 1'b1) $display("FAIL b2b_ready_start: got %b required 1", SYM_READY); else passed++;
    SYM_VALID = 1'b1; SYM_LEN = 3'd1; SYM_CODE = 5'b00000;
    @(posedge CLK);
    @(negedge CLK);
    SYM_LEN = 3'd1; SYM_CODE = 5'b00001;
    $display("sent E then holding T");
    observe(40);
    SYM_VALID = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL b2b_run: got %0d required %0d", o, e);
      else passed++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL b2b_extra_runs: got %0d required 0", obs_q.size()); else passed++;
    obs_q.delete();
    total++;
    if (transfers !== 1) $display("FAIL b2b_transfers: got %0d required 1", transfers); else passed++;
    total++;
    if (ready_at !== 16) $display("FAIL b2b_ready: got %0d required 16", ready_at); else passed++;
    total++;
    if (overlap !== 0) $display("FAIL b2b_ready_while_busy: got %0d required 0", overlap); else passed++;
  endtask

  task automatic test_clamp();
    int e, o;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(1012);
      exp_q.push_back(4);
    end
    exp_q.push_back(1012); exp_q.push_back(16);
    send_sym(3'd7, 5'b11111);
    observe(92);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL clamp_run: got %0d required %0d", o, e);
      else passed++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL clamp_extra_runs: got %0d required 0", obs_q.size()); else passed++;
    obs_q.delete();
    total++;
    if (ready_at !== 88) $display("FAIL clamp_ready: got %0d required 88", ready_at); else passed++;
    total++;
    if (ticks !== 22) $display("FAIL clamp_ticks: got %0d required 22", ticks); else passed++;
  endtask

  task automatic test_reset_mid();
    int e, o;
    send_sym(3'd2, 5'b00010);
    repeat (10) @(negedge CLK);
    total++;
    if (MORSE_OUT !== 1'b1) $display("FAIL mid_second_mark: MORSE_OUT=%b required 1", MORSE_OUT); else passed++;
    RESET_N = 1'b0;
    #1;
    total++;
    if ({MORSE_OUT, BUSY, UNIT_TICK, SYM_READY} !== 4'b0000)
      $display("FAIL mid_reset_outputs: out/busy/tick/ready=%b required 0000", {MORSE_OUT, BUSY, UNIT_TICK, SYM_READY});
    else passed++;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    total++;
    if (SYM_READY !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL mid_release: ready=%b busy=%b required 1 0", SYM_READY, BUSY);
    else passed++;
    exp_q.push_back(1004); exp_q.push_back(16);
    send_sym(3'd1, 5'b00000);
    observe(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL mid_e_run: got %0d required %0d", o, e);
      else passed++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL mid_extra_runs: got %0d required 0", obs_q.size()); else passed++;
    obs_q.delete();
    total++;
    if (ready_at !== 16) $display("FAIL mid_e_ready: got %0d required 16", ready_at); else passed++;
  endtask

`ifdef MORSE_TONE_EN
  task automatic test_tone();
    logic tone_q[$];
    logic e;
    for (int i = 0; i < 12; i++) tone_q.push_back((i == 2) || (i == 3));
    send_sym(3'd1, 5'b00000);
    for (int i = 0; i < 12; i++) begin
      e = tone_q.pop_front();
      total++;
      if (TONE_OUT !== e) $display("FAIL tone_cycle%0d: TONE_OUT=%b required %b", i, TONE_OUT, e);
      else passed++;
      @(negedge CLK);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_letter_a();
    test_word_space();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
`ifdef MORSE_TONE_EN
    test_tone();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
